// File: rtl/soc_timer_pkg.sv
// soc_timer register map, bus access types and read-modify-write helper.
// SOC_TIMER_ONESHOT_EN widens the CONTROL write mask to include ONESHOT.
package soc_timer_pkg;

  localparam int unsigned TIMER_MAX_COUNT = 16;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned REG_ADDR_W      = 10;
  localparam int unsigned CTRL_W          = 3;
  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_IRQ_EN     = 1;
  localparam int unsigned CTRL_ONESHOT    = 2;

`ifdef SOC_TIMER_ONESHOT_EN
  localparam logic [CTRL_W-1:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [CTRL_W-1:0] CTRL_WMASK = 3'b011;
`endif

  typedef enum logic [1:0] {
    ACC_MAIN   = 2'd0,
    ACC_SET    = 2'd1,
    ACC_CLEAR  = 2'd2,
    ACC_TOGGLE = 2'd3
  } reg_access_t;

  typedef enum logic [3:0] {
    REG_CONTROL   = 4'd0,
    REG_PRESCALER = 4'd1,
    REG_TOP       = 4'd2,
    REG_COUNT     = 4'd3,
    REG_STATUS    = 4'd4
  } timer_conf_t;

  // Word address bits [11:2]: channel, register, access type.
  typedef struct packed {
    logic [3:0]  ch;
    timer_conf_t sel;
    reg_access_t acc;
  } timer_addr_t;

  function automatic logic [DATA_W-1:0] apply_access(input logic [DATA_W-1:0] cur,
                                                     input logic [DATA_W-1:0] data,
                                                     input reg_access_t acc);
    case (acc)
      ACC_SET:    apply_access = cur | data;
      ACC_CLEAR:  apply_access = cur & ~data;
      ACC_TOGGLE: apply_access = cur ^ data;
      default:    apply_access = data;
    endcase
  endfunction

endpackage

// File: rtl/SoC_MemBus.sv
// SoC register bus: single-cycle write strobe, read request with delayed rdata/rvalid.
interface SoC_MemBus;
  logic [31:0] addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport Slave  (input addr, we, re, wdata, output rdata, rvalid);
  modport Master (output addr, we, re, wdata, input rdata, rvalid);
endinterface

// File: rtl/soc_peripheral_controller.sv
// Peripheral bus front end: forwards writes, returns read data BUS_LATENCY cycles later.
module soc_peripheral_controller import soc_timer_pkg::*; #(
  parameter int unsigned BUS_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  SoC_MemBus.Slave              bus,
  output logic [REG_ADDR_W-1:0] reg_addr_c,
  output logic                  we_c,
  output logic [DATA_W-1:0]     wdata_c,
  input  logic [DATA_W-1:0]     rdata_c
);

  logic [DATA_W-1:0] rd_pipe [BUS_LATENCY];
  logic              rv_pipe [BUS_LATENCY];
  logic              unused_addr;

  if (BUS_LATENCY < 1) begin : g_bad_latency
    $error("soc_peripheral_controller: BUS_LATENCY must be at least 1");
  end

  assign reg_addr_c  = bus.addr[REG_ADDR_W+1:2];
  assign unused_addr = ^{bus.addr[31:REG_ADDR_W+2], bus.addr[1:0]};
  assign we_c        = bus.we;
  assign wdata_c     = bus.wdata;
  assign bus.rdata   = rd_pipe[BUS_LATENCY-1];
  assign bus.rvalid  = rv_pipe[BUS_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BUS_LATENCY; k++) begin
        rd_pipe[k] <= '0;
        rv_pipe[k] <= 1'b0;
      end
    end else begin
      rd_pipe[0] <= bus.re ? rdata_c : '0;
      rv_pipe[0] <= bus.re;
      for (int k = 1; k < BUS_LATENCY; k++) begin
        rd_pipe[k] <= rd_pipe[k-1];
        rv_pipe[k] <= rv_pipe[k-1];
      end
    end
  end

endmodule

// File: rtl/soc_timer_channel.sv
// One timer channel: prescale counter, up-counter wrapping at TOP, optional one-shot stop.
// SOC_TIMER_ONESHOT_EN enables the EN clear request on a wrapping tick.
module soc_timer_channel import soc_timer_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              oneshot,
  input  logic              restart,
  input  logic              load,
  input  logic [DATA_W-1:0] presc,
  input  logic [DATA_W-1:0] top_val,
  input  logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] count,
  output logic              wrap_c,
  output logic              clear_en_c
);

  logic [DATA_W-1:0] pc;
  logic              tick_c;

  assign tick_c = en && (pc == presc);
  // A software count load in the same cycle suppresses the tick entirely.
  assign wrap_c = tick_c && !load && (count >= top_val);

`ifdef SOC_TIMER_ONESHOT_EN
  assign clear_en_c = wrap_c && oneshot;
`else
  logic unused_oneshot;
  assign unused_oneshot = oneshot;
  assign clear_en_c     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      count <= '0;
    end else if (load) begin
      count <= load_val;
      pc    <= '0;
    end else if (restart) begin
      pc <= '0;
    end else if (tick_c) begin
      pc    <= '0;
      count <= wrap_c ? '0 : count + DATA_W'(1);
    end else if (en) begin
      pc <= pc + DATA_W'(1);
    end
  end

endmodule

// File: rtl/soc_timer.sv
// Memory-mapped multi-channel timer feeding the PWM controller's timer_counts.
// SOC_TIMER_ONESHOT_EN enables CONTROL.ONESHOT (see soc_timer_pkg / soc_timer_channel).
module soc_timer import soc_timer_pkg::*; #(
  parameter int unsigned BUS_LATENCY = 1,
  parameter int unsigned TIMER_COUNT = 1
) (
  input  logic                   clk,
  input  logic                   res,
  output logic [DATA_W-1:0]      timer_counts [TIMER_COUNT],
  output logic [TIMER_COUNT-1:0] irq,
  SoC_MemBus.Slave               mem_bus
);

  logic [REG_ADDR_W-1:0]  reg_addr_c;
  logic                   we_c;
  logic [DATA_W-1:0]      wdata_c;
  logic [DATA_W-1:0]      rdata_c;
  timer_addr_t            req;

  logic [CTRL_W-1:0]      ctrl_q  [TIMER_COUNT];
  logic [CTRL_W-1:0]      ctrl_d  [TIMER_COUNT];
  logic [DATA_W-1:0]      presc_q [TIMER_COUNT];
  logic [DATA_W-1:0]      presc_d [TIMER_COUNT];
  logic [DATA_W-1:0]      top_q   [TIMER_COUNT];
  logic [DATA_W-1:0]      top_d   [TIMER_COUNT];
  logic [DATA_W-1:0]      cur_val [TIMER_COUNT];
  logic [DATA_W-1:0]      wval    [TIMER_COUNT];
  logic [TIMER_COUNT-1:0] flag_q, flag_d, irq_d;
  logic [TIMER_COUNT-1:0] wr_hit, load, restart, wrap_c, clear_en_c;

  if (TIMER_COUNT < 1 || TIMER_COUNT > TIMER_MAX_COUNT) begin : g_bad_count
    $error("soc_timer: TIMER_COUNT must be 1..16");
  end

  soc_peripheral_controller #(.BUS_LATENCY(BUS_LATENCY)) u_bus (
    .clk        (clk),
    .rst_n      (res),
    .bus        (mem_bus),
    .reg_addr_c (reg_addr_c),
    .we_c       (we_c),
    .wdata_c    (wdata_c),
    .rdata_c    (rdata_c)
  );

  assign req = timer_addr_t'(reg_addr_c);

  // Addressed register per channel, used for read-back and SET/CLEAR/TOGGLE writes.
  always_comb begin
    for (int i = 0; i < TIMER_COUNT; i++) begin
      cur_val[i] = '0;
      case (req.sel)
        REG_CONTROL:   cur_val[i] = DATA_W'(ctrl_q[i]);
        REG_PRESCALER: cur_val[i] = presc_q[i];
        REG_TOP:       cur_val[i] = top_q[i];
        REG_COUNT:     cur_val[i] = timer_counts[i];
        REG_STATUS:    cur_val[i] = DATA_W'(flag_q[i]);
        default:       cur_val[i] = '0;
      endcase
      wval[i] = apply_access(cur_val[i], wdata_c, req.acc);
    end
  end

  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < TIMER_COUNT; i++) begin
      if (req.ch == 4'(i) && req.acc == ACC_MAIN) rdata_c = cur_val[i];
    end
  end

  // Register next-state: software write first, then hardware EN clear and FLAG set win.
  always_comb begin
    for (int i = 0; i < TIMER_COUNT; i++) begin
      ctrl_d[i]  = ctrl_q[i];
      presc_d[i] = presc_q[i];
      top_d[i]   = top_q[i];
      flag_d[i]  = flag_q[i];
      load[i]    = 1'b0;
      restart[i] = 1'b0;
      wr_hit[i]  = we_c && (req.ch == 4'(i));
      if (wr_hit[i]) begin
        case (req.sel)
          REG_CONTROL: begin
            ctrl_d[i]  = wval[i][CTRL_W-1:0] & CTRL_WMASK;
            restart[i] = !ctrl_q[i][CTRL_EN] && wval[i][CTRL_EN];
          end
          REG_PRESCALER: presc_d[i] = wval[i];
          REG_TOP:       top_d[i]   = wval[i];
          REG_COUNT:     load[i]    = 1'b1;
          REG_STATUS:    flag_d[i]  = flag_q[i] & wval[i][0];
          default:       ;
        endcase
      end
      if (clear_en_c[i]) ctrl_d[i][CTRL_EN] = 1'b0;
      if (wrap_c[i])     flag_d[i] = 1'b1;
      irq_d[i] = flag_d[i] & ctrl_d[i][CTRL_IRQ_EN];
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < TIMER_COUNT; i++) begin
        ctrl_q[i]  <= '0;
        presc_q[i] <= '0;
        top_q[i]   <= '0;
      end
      flag_q <= '0;
      irq    <= '0;
    end else begin
      for (int i = 0; i < TIMER_COUNT; i++) begin
        ctrl_q[i]  <= ctrl_d[i];
        presc_q[i] <= presc_d[i];
        top_q[i]   <= top_d[i];
      end
      flag_q <= flag_d;
      irq    <= irq_d;
    end
  end

  for (genvar g = 0; g < TIMER_COUNT; g++) begin : g_ch
    soc_timer_channel u_ch (
      .clk        (clk),
      .rst_n      (res),
      .en         (ctrl_q[g][CTRL_EN]),
      .oneshot    (ctrl_q[g][CTRL_ONESHOT]),
      .restart    (restart[g]),
      .load       (load[g]),
      .presc      (presc_q[g]),
      .top_val    (top_q[g]),
      .load_val   (wval[g]),
      .count      (timer_counts[g]),
      .wrap_c     (wrap_c[g]),
      .clear_en_c (clear_en_c[g])
    );
  end

endmodule

// File: tb/tb_soc_timer.sv
// Directed bench for soc_timer (two channels); read results checked through an expected-value queue.
module tb_soc_timer;
  import soc_timer_pkg::*;

  localparam int unsigned N_CH = 2;
`ifdef SOC_TIMER_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              res;
  logic [31:0]       timer_counts [N_CH];
  logic [N_CH-1:0]   irq;

  SoC_MemBus bus();

  soc_timer #(.BUS_LATENCY(1), .TIMER_COUNT(N_CH)) dut (
    .clk          (clk),
    .res          (res),
    .timer_counts (timer_counts),
    .irq          (irq),
    .mem_bus      (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input int ch, input timer_conf_t sel, input reg_access_t acc,
                    input logic [31:0] data);
    bus.addr  = {20'd0, 4'(ch), sel, acc, 2'b00};
    bus.wdata = data;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic rd(input int ch, input timer_conf_t sel, input reg_access_t acc,
                    input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus.addr = {20'd0, 4'(ch), sel, acc, 2'b00};
    bus.re   = 1'b1;
    @(negedge clk);
    bus.re   = 1'b0;
    for (int w = 0; w < 8 && !bus.rvalid; w++) @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check(t, bus.rdata, e);
  endtask

  initial begin
    res       = 1'b0;
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    res = 1'b1;

    check("rst_cnt0", timer_counts[0], 32'd0);
    check("rst_cnt1", timer_counts[1], 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rd(0, REG_CONTROL, ACC_MAIN, 32'd0, "rst_ctrl0");

    // P=0, T=3 on ch0 with IRQ_EN.
    wr(0, REG_TOP, ACC_MAIN, 32'd3);
    wr(0, REG_CONTROL, ACC_MAIN, 32'h3);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("p0_cnt%0d", k), timer_counts[0], 32'(k % 4));
      check($sformatf("p0_irq%0d", k), 32'(irq[0]), 32'(k == 4));
      if (k < 4) @(negedge clk);
    end
    wr(0, REG_STATUS, ACC_MAIN, 32'd0);
    check("stclr_irq", 32'(irq[0]), 32'd0);
    check("stclr_cnt", timer_counts[0], 32'd1);
    repeat (2) @(negedge clk);
    check("prewrap_cnt", timer_counts[0], 32'd3);
    wr(0, REG_STATUS, ACC_CLEAR, 32'd1);
    check("race_cnt", timer_counts[0], 32'd0);
    check("race_irq", 32'(irq[0]), 32'd1);
    wr(0, REG_CONTROL, ACC_MAIN, 32'd0);
    check("irqen_clr_irq", 32'(irq[0]), 32'd0);
    check("stop0_cnt", timer_counts[0], 32'd1);
    rd(0, REG_STATUS, ACC_MAIN, 32'd1, "race_flag");
    check("stop0_hold", timer_counts[0], 32'd1);

    // P=2, T=1 on ch1: count changes every 3 clocks.
    wr(1, REG_PRESCALER, ACC_MAIN, 32'd2);
    wr(1, REG_TOP, ACC_MAIN, 32'd1);
    wr(1, REG_CONTROL, ACC_MAIN, 32'd1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("p2_cnt%0d", k), timer_counts[1], 32'((k / 3) % 2));
      if (k < 9) @(negedge clk);
    end
    wr(1, REG_CONTROL, ACC_MAIN, 32'd0);
    repeat (7) @(negedge clk);
    check("p2_freeze", timer_counts[1], 32'd1);
    rd(1, REG_STATUS, ACC_MAIN, 32'd1, "p2_flag");
    rd(1, REG_COUNT, ACC_MAIN, 32'd1, "p2_cnt_rd");

    // SET/CLEAR/TOGGLE read-modify-write; non-MAIN reads return 0.
    wr(1, REG_PRESCALER, ACC_SET, 32'h10);
    wr(1, REG_PRESCALER, ACC_TOGGLE, 32'h3);
    wr(1, REG_PRESCALER, ACC_CLEAR, 32'h1);
    rd(1, REG_PRESCALER, ACC_MAIN, 32'h10, "acc_rmw");
    rd(1, REG_PRESCALER, ACC_SET, 32'd0, "acc_nonmain");

    // COUNT write coinciding with a tick wins; next tick wraps from above TOP.
    wr(0, REG_STATUS, ACC_MAIN, 32'd0);
    wr(0, REG_TOP, ACC_MAIN, 32'd5);
    wr(0, REG_CONTROL, ACC_MAIN, 32'd1);
    check("ld_pre", timer_counts[0], 32'd1);
    wr(0, REG_COUNT, ACC_MAIN, 32'd10);
    check("ld_win", timer_counts[0], 32'd10);
    @(negedge clk);
    check("ld_wrap", timer_counts[0], 32'd0);
    check("ld_irq_off", 32'(irq[0]), 32'd0);
    rd(0, REG_STATUS, ACC_MAIN, 32'd1, "ld_flag");
    wr(0, REG_CONTROL, ACC_MAIN, 32'd0);
    check("ld_stop", timer_counts[0], 32'd2);

    // Out-of-range channel index: writes ignored, reads 0.
    wr(5, REG_TOP, ACC_MAIN, 32'h55);
    wr(5, REG_CONTROL, ACC_MAIN, 32'd1);
    wr(5, REG_COUNT, ACC_MAIN, 32'd7);
    rd(5, REG_TOP, ACC_MAIN, 32'd0, "ch5_top");
    rd(5, REG_CONTROL, ACC_MAIN, 32'd0, "ch5_ctrl");
    rd(0, REG_TOP, ACC_MAIN, 32'd5, "ch5_ch0_top");
    rd(1, REG_TOP, ACC_MAIN, 32'd1, "ch5_ch1_top");
    check("ch5_cnt0", timer_counts[0], 32'd2);
    check("ch5_cnt1", timer_counts[1], 32'd1);

    // CONTROL=0x7, P=0, T=2 on ch1: one-shot stops after the first wrap.
    wr(1, REG_PRESCALER, ACC_MAIN, 32'd0);
    wr(1, REG_TOP, ACC_MAIN, 32'd2);
    wr(1, REG_COUNT, ACC_MAIN, 32'd0);
    wr(1, REG_STATUS, ACC_MAIN, 32'd0);
    wr(1, REG_CONTROL, ACC_MAIN, 32'h7);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("os_cnt%0d", k), timer_counts[1],
            ONESHOT ? 32'((k <= 2) ? k : 0) : 32'(k % 3));
      if (k < 5) @(negedge clk);
    end
    check("os_irq", 32'(irq[1]), 32'd1);
    rd(1, REG_CONTROL, ACC_MAIN, ONESHOT ? 32'h6 : 32'h3, "os_ctrl");

    // Asynchronous reset mid-count.
    wr(0, REG_COUNT, ACC_MAIN, 32'd0);
    wr(0, REG_CONTROL, ACC_MAIN, 32'h3);
    repeat (3) @(negedge clk);
    check("prerst_cnt0", timer_counts[0], 32'd3);
    check("prerst_irq1", 32'(irq[1]), 32'd1);
    #2 res = 1'b0;
    #1;
    check("arst_cnt0", timer_counts[0], 32'd0);
    check("arst_cnt1", timer_counts[1], 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    res = 1'b1;
    rd(0, REG_CONTROL, ACC_MAIN, 32'd0, "arst_ctrl0");
    rd(0, REG_TOP, ACC_MAIN, 32'd0, "arst_top0");
    rd(1, REG_TOP, ACC_MAIN, 32'd0, "arst_top1");
    rd(1, REG_STATUS, ACC_MAIN, 32'd0, "arst_flag1");
    check("arst_hold0", timer_counts[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
